// File: rtl/uart_tx_axis.sv
// UART transmitter fed by an AXI-Stream slave through a small FIFO.
// Frames are start bit, DATA_BITS data bits LSB first, one stop bit.
module uart_tx_axis #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_BITS-1:0]          s_axis_tdata,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   output logic                          tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD;
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int CW       = AW + 1;
   localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int NW       = $clog2(DATA_BITS) + 1;

   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_BITS - 1);
   localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t               state_q, state_d;
   logic [BW-1:0]        baud_q, baud_d;
   logic [NW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic [AW-1:0]        rd_q, rd_d;
   logic [AW-1:0]        wr_q, wr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

   logic push;
   logic pop;
   logic baud_end;
   logic fifo_ne;

   assign s_axis_tready = (cnt_q != FULL);
   assign push          = s_axis_tvalid && s_axis_tready;
   assign fifo_ne       = (cnt_q != '0);
   assign baud_end      = (baud_q == BAUD_LAST);

   assign tx         = tx_q;
   assign tx_busy    = (state_q != IDLE);
   assign fifo_count = cnt_q;

   // Frame sequencer: next state, counters, shifter and FIFO pop.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fifo_ne) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_q];
               baud_d  = '0;
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d = '0;
               bit_d  = '0;
               if (fifo_ne) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_q];
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level for the coming cycle, so tx leaves a flop.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // FIFO pointer and occupancy update.
   always_comb begin
      wr_d  = push ? wr_q + 1'b1 : wr_q;
      rd_d  = pop ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // FIFO storage; contents need no reset since count gates reads.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wr_q] <= s_axis_tdata;
      end
   end

   // State register; reset aborts any frame and flushes the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_axis.sv
// Bench for uart_tx_axis: a line-level receiver model decodes tx frames
// and checks them against a queue of the words the driver got accepted.
`timescale 1ns/1ps
module tb_uart_tx_axis;

   localparam int CLK_FREQ = 1_000_000;
   localparam int BAUD     = 100_000;
   localparam int DIV      = CLK_FREQ / BAUD;
   localparam int FRAME    = 10 * DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_axis_tdata = 8'h00;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tready;
   logic       tx;
   logic       tx_busy;
   logic [2:0] fifo_count;

   uart_tx_axis #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .DATA_BITS (8),
      .FIFO_DEPTH(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .tx           (tx),
      .tx_busy      (tx_busy),
      .fifo_count   (fifo_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_q[$];
   int falls_q[$];
   int frames = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Offer one word; returns the cycle of the accepting edge.
   // While the word cannot be taken, tdata carries junk.
   task automatic send(input logic [7:0] d, output int ac);
      int  n;
      bit  go;
      bit  done;
      n    = 0;
      done = 0;
      ac   = -1;
      s_axis_tvalid = 1'b1;
      while (!done) begin
         go = s_axis_tready;
         s_axis_tdata = go ? d : 8'($urandom);
         @(posedge clk); #1;
         if (go) begin
            done = 1;
            ac   = cyc;
            exp_q.push_back(d);
         end else if (++n > 3000) begin
            check("accept_timeout", 0, 1);
            done = 1;
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_frames(input int target);
      int n;
      n = 0;
      while (frames < target && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check("frame_start_timeout", 32'(frames >= target), 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || tx_busy) && n < 40000) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_timeout", 32'(n < 40000), 1);
      idle(3);
   endtask

   // Receiver model: a falling line starts a frame of 10 bit times;
   // each bit is sampled in its middle. Reset aborts the frame.
   initial begin : monitor
      logic [9:0] fb;
      int         fc;
      bit         ab;
      bit         bok;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            fc = cyc;
            falls_q.push_back(fc);
            frames++;
            ab  = 0;
            bok = 1;
            fb  = '0;
            for (int k = 0; k < FRAME; k++) begin
               if (k > 0) @(negedge clk);
               if (rst) begin
                  ab = 1;
                  break;
               end
               if (tx_busy !== 1'b1) bok = 0;
               if (k % DIV == DIV / 2) fb[k/DIV] = tx;
            end
            if (!ab) begin
               check("framing_start_stop", {30'd0, fb[9], fb[0]}, 2);
               check("busy_whole_frame", 32'(bok), 1);
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", {24'd0, fb[8:1]}, 32'hFFFF);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_data", {24'd0, fb[8:1]}, {24'd0, e});
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int ac0, ac1, nf;
      int acc[6];
      logic [7:0] w[6];

      idle(3);
      check("rst_tx", 32'(tx), 1);
      check("rst_busy", 32'(tx_busy), 0);
      check("rst_count", 32'(fifo_count), 0);
      check("rst_tready", 32'(s_axis_tready), 1);

      // Words offered during reset are dropped.
      s_axis_tvalid = 1'b1;
      repeat (3) begin
         s_axis_tdata = 8'($urandom);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      s_axis_tvalid = 1'b0;
      nf = frames;
      idle(1);
      check("rst_drop_count", 32'(fifo_count), 0);
      idle(2 * FRAME);
      check("rst_drop_frames", frames, nf);

      // Single byte: line falls the edge after acceptance.
      nf = frames;
      send(8'h55, ac0);
      check("single_count", 32'(fifo_count), 1);
      wait_frames(nf + 1);
      check("single_latency", falls_q[$] - ac0, 1);
      wait_idle();
      check("single_busy_after", 32'(tx_busy), 0);

      // Back-to-back: no idle gap between frames.
      nf = frames;
      send(8'hA5, ac0);
      check("b2b_count_a", 32'(fifo_count), 1);
      send(8'h3C, ac1);
      check("b2b_count_b", 32'(fifo_count), 1);
      wait_frames(nf + 2);
      check("b2b_gap", falls_q[$] - falls_q[$-1], FRAME);
      wait_idle();
      check("b2b_count_end", 32'(fifo_count), 0);

      // Backpressure: FIFO plus shifter absorb five words.
      for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
         send(w[i], acc[i]);
         s_axis_tvalid = 1'b1;
         if (i == 4) begin
            check("bp_full_count", 32'(fifo_count), 4);
            check("bp_full_tready", 32'(s_axis_tready), 0);
         end
      end
      s_axis_tvalid = 1'b0;
      for (int i = 1; i < 5; i++)
         check("bp_consecutive", acc[i] - acc[0], i);
      check("bp_sixth_accept", acc[5] - acc[0], FRAME + 2);
      wait_idle();

      // Reset during data bit 3 with two words queued.
      nf = frames;
      send(8'hC3, ac0);
      send(8'h18, ac1);
      send(8'h7E, ac1);
      wait_frames(nf + 1);
      while (cyc < falls_q[$] + 4 * DIV + 4) begin
         @(posedge clk); #1;
      end
      check("mid_queued", 32'(fifo_count), 2);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_tx", 32'(tx), 1);
      check("mid_busy", 32'(tx_busy), 0);
      check("mid_count", 32'(fifo_count), 0);
      check("mid_tready", 32'(s_axis_tready), 1);
      rst = 1'b0;
      exp_q.delete();
      nf = frames;
      idle(3 * FRAME);
      check("mid_no_frames", frames, nf);

      // Random stream with random gaps and bursts.
      for (int i = 0; i < 256; i++) begin
         send(8'($urandom), ac0);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 150));
      end
      wait_idle();
      check("stream_drained", exp_q.size(), 0);
      check("stream_count", 32'(fifo_count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_axis.md
# uart_tx_axis

UART transmitter with an AXI-Stream slave input. Bytes are accepted over a valid/ready handshake into a small FIFO and serialized on `tx` as 8N1-style frames: one start bit, DATA_BITS data bits LSB first, one stop bit. It is the transmit-side counterpart of the team's UART receiver and sits between the on-chip stream fabric and the serial pin.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `DATA_BITS`, default 8: data bits per frame.
- `FIFO_DEPTH`, default 4: entries in the input FIFO; must be a power of 2 and ≥ 2.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `s_axis_tdata` in DATA_BITS: byte to transmit.
- `s_axis_tvalid` in 1: `s_axis_tdata` is valid.
- `s_axis_tready` out 1: FIFO can accept a word.
- `tx` out 1: serial line, registered, idle high.
- `tx_busy` out 1: high while a frame is on the line (state ≠ IDLE).
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of queued words, not counting the one being shifted.

## Operation
- `BAUD_DIV` = CLK_FREQ/BAUD, integer-truncated.
  - Every bit (start, data, stop) lasts exactly BAUD_DIV cycles.
  - Baud counter runs 0..BAUD_DIV-1 and wraps to 0 on the last cycle of each bit.
- Handshake:
  - A transfer occurs on an edge where `s_axis_tvalid` and `s_axis_tready` are both high and `rst` is low.
  - `s_axis_tready` = (fifo_count ≠ FIFO_DEPTH), driven from registered count.
  - Words presented while `rst` is high are discarded.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - No push when full. No pop when empty.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If FIFO is non-empty, pop the head into the shift register, clear baud and bit counters, and go to START.
  - START: `tx`=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: `tx`=shift_reg[0]. At each bit end, shift right and increment the bit counter. After bit DATA_BITS-1 ends, go to STOP.
  - STOP: `tx`=1 for BAUD_DIV cycles. On the last stop cycle:
    - FIFO non-empty: pop and go directly to START (no idle gap).
    - Otherwise: go to IDLE.
- Reset values:
  - `tx`=1, `tx_busy`=0, `fifo_count`=0, `s_axis_tready`=1.
  - State is IDLE; pointers, counters and shift register are 0.
- Reset mid-frame:
  - Frame is aborted and the FIFO is flushed.
  - `tx` returns high on the reset edge.
  - No partial frame resumes after reset.
- `tdata` is sampled only on a transfer edge; changes while not accepted are ignored.

## Timing
- Latency: with FIFO empty and FSM in IDLE, a word accepted at edge N is popped at edge N+1. `tx` falls and `tx_busy` rises on edge N+1.
- Frame length is (DATA_BITS+2)·BAUD_DIV cycles, from `tx` falling to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit cycle. Stop bit is exactly BAUD_DIV cycles.
- `fifo_count`:
  - Increments on the edge after a push-only cycle.
  - Decrements on a pop-only edge.
  - `s_axis_tready` follows on the same edge.
- Throughput bound: one word per frame time; the FIFO absorbs bursts up to FIFO_DEPTH+1 words (FIFO plus shifter).

## Test plan
- **Single byte:** CLK_FREQ=1_000_000, BAUD=100_000 (BAUD_DIV=10). Push 0x55 → `tx` falls 1 cycle after the accept edge. Line carries 0,1,0,1,0,1,0,1,0,1, each for 10 cycles, then high. `tx_busy` is high for 100 cycles.
- **Back-to-back:** push 0xA5 then 0x3C on consecutive cycles → two contiguous 100-cycle frames (bits LSB first: 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0), no idle cycle between stop and second start. `fifo_count` goes 0→1→0.
- **Backpressure:** FIFO_DEPTH=4, hold `tvalid` with 6 distinct words → exactly 5 accepted in 5 consecutive cycles. `s_axis_tready` drops with `fifo_count`=4. Sixth word is accepted after the first frame completes. All 6 are transmitted in order.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 3 with 2 words queued → `tx`=1, `tx_busy`=0, `fifo_count`=0, `s_axis_tready`=1 after the edge. No further frames appear.
- **Loopback:** drive `tx` into the team's UART receiver with matching parameters. Send 256 random bytes with random `tvalid` gaps → every byte is received intact and in order.
- **Ignored input:** `tvalid` high with `rst` high, and `tdata` toggling while `tready`=0 → nothing enqueued, transmitted data unaffected.
